rx_frame_parser: RTL
====================

// Module: rx_frame_parser
// PURPOSE
//  Consumes the byte stream from the UART receive path (valid/ready, post-FIFO) and extracts framed commands.
//  Frame = SOF, CMD, LEN, LEN payload bytes, CHK; CHK = XOR of CMD, LEN and all payload bytes.
//  Payload is buffered and released downstream only after the checksum passes. Bad frames are dropped and flagged.
// PARAMETERS
//  DATA_WIDTH    8                                    byte width
//  MAX_LEN       16                                   max payload bytes per frame (>=1)
//  SOF_BYTE      8'hA5                                start-of-frame marker
//  BAUDRATE      9600                                 line rate, used only for the timeout default
//  CLK_FREQ_MHZ  125                                  clk frequency, used only for the timeout default
//  TIMEOUT_CYC   4*10*CLK_FREQ_MHZ*1000000/BAUDRATE   max idle clocks between bytes inside a frame
// PORTS
//  clk          in   1                        system clock
//  rst          in   1                        asynchronous reset, active-high
//  in_data      in   DATA_WIDTH               byte from the RX read stage
//  in_valid     in   1                        in_data valid
//  in_ready     out  1                        parser accepts a byte this cycle
//  out_data     out  DATA_WIDTH               payload byte
//  out_valid    out  1                        out_data valid
//  out_ready    in   1                        consumer accepts the payload byte
//  out_last     out  1                        final payload byte of the frame
//  frame_ok     out  1                        1-cycle pulse: good frame latched
//  frame_cmd    out  DATA_WIDTH               CMD of the last good frame
//  frame_len    out  $clog2(MAX_LEN+1)        LEN of the last good frame
//  err_chk      out  1                        1-cycle pulse: checksum mismatch
//  err_len      out  1                        1-cycle pulse: LEN > MAX_LEN
//  err_timeout  out  1                        1-cycle pulse: inter-byte timeout
//  busy         out  1                        state != HUNT
// BEHAVIOUR
//  - Reset: state HUNT. All registered outputs, indices, checksum and timer are 0. in_ready = ~rst & (state != SEND).
//  - A byte is accepted when in_valid && in_ready. All state transitions below occur on accepted bytes, except SEND and timeout.
//  - HUNT: SOF_BYTE -> CMD. Any other byte is discarded silently.
//  - CMD: latch cmd, chk = byte -> LEN.
//  - LEN: if byte > MAX_LEN -> err_len, HUNT.
//    Otherwise latch len, chk ^= byte, wr_idx = 0. Go to CHK if len == 0, else PAY.
//  - PAY: buf[wr_idx] = byte, chk ^= byte, wr_idx++. After byte number len -> CHK.
//    SOF_BYTE has no special meaning inside a frame.
//  - CHK, byte != chk: err_chk, HUNT. The buffer is not emitted.
//  - CHK, byte == chk: frame_ok pulses in the next cycle, and frame_cmd/frame_len update in that same cycle.
//    len == 0 -> HUNT. Otherwise SEND with rd_idx = 0.
//  - SEND: in_ready = 0. out_valid = 1, out_data = buf[rd_idx], out_last = (rd_idx == len-1).
//    On out_ready, rd_idx++. On the last handshake -> HUNT; out_valid drops in the next cycle.
//    out_data and out_last stay stable while out_valid && !out_ready.
//  - Timer: counts in CMD/LEN/PAY/CHK and clears on every accepted byte; held at 0 in HUNT/SEND.
//    Reaching TIMEOUT_CYC-1 -> err_timeout, HUNT.
//    If a byte is accepted in that same cycle, the byte wins and the timer clears.
//  - Error pulses are mutually exclusive and registered (1 cycle after the cause). frame_cmd/frame_len are unchanged on error.
//  - Latency: last CHK byte accepted -> frame_ok at +1 cycle; first out_valid at +1 cycle.
//  - rst mid-frame or mid-SEND: the frame is abandoned, out_valid drops immediately, and no error pulse is raised.
// STRUCTURE
//  - Shared header uart_defs.vh: SOF_BYTE default, state encodings (HUNT, CMD, LEN, PAY, CHK, SEND), and a byte-time macro.
//  - Sub-module frame_buf: MAX_LEN x DATA_WIDTH register file with 1 sync write port and 1 async read port.
//  - All control logic stays in this module.
// TESTING
//  1. Good frame: A5 01 02 11 22 30.
//     -> frame_ok, cmd=01, len=2; beats 11, 22 (last); no error pulses.
//  2. Garbage before the frame: 00 FF 5A A5 07 00 07.
//     -> junk ignored; frame_ok with cmd=07, len=0; no out_valid.
//  3. Bad checksum: A5 01 02 11 22 31.
//     -> err_chk; no out_valid; frame_cmd/len keep their previous values.
//  4. Oversize length: A5 03 20.
//     -> err_len 1 cycle after the LEN byte; a following good frame parses correctly.
//  5. Backpressure: test 1 with out_ready=0 for 5 cycles.
//     -> out_data=11 held stable, in_ready=0 throughout, no byte lost.
//  6. Timeout and reset, with TIMEOUT_CYC=50:
//     - A5 01 then 60 idle cycles -> err_timeout once, busy=0.
//     - rst during PAY -> outputs 0, next frame OK.

Source files
------------

// File: rtl/rx_frame_parser_pkg.sv
// -----------------------------------------------------------------------------
// rx_frame_parser_pkg
//   Shared definitions for the UART receive frame parser:
//     - parser state encoding
//     - default start-of-frame marker
//     - byte-time based default for the inter-byte timeout
//   No ports (package).
// -----------------------------------------------------------------------------
package rx_frame_parser_pkg;

  typedef enum logic [2:0] {
    ST_HUNT = 3'd0,
    ST_CMD  = 3'd1,
    ST_LEN  = 3'd2,
    ST_PAY  = 3'd3,
    ST_CHK  = 3'd4,
    ST_SEND = 3'd5
  } state_e;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  // One UART character on the wire: start + 8 data + stop.
  localparam int BITS_PER_BYTE = 10;

  // A sender may pause for this many character times between bytes of one frame.
  localparam int TIMEOUT_BYTES = 4;

  // Idle clocks allowed between bytes inside a frame. The product exceeds
  // 32 bits at typical clock rates, so it is formed in 64-bit arithmetic.
  function automatic int timeout_default(input int clk_mhz, input int baud);
    longint num;
    num = longint'(TIMEOUT_BYTES * BITS_PER_BYTE) * longint'(clk_mhz) * 64'sd1000000;
    return int'(num / longint'(baud));
  endfunction

endpackage

// File: rtl/rx_frame_parser_buf.sv
// -----------------------------------------------------------------------------
// rx_frame_parser_buf
//   Payload holding buffer: DEPTH x DATA_WIDTH register file, one synchronous
//   write port and one asynchronous read port.
// Ports
//   clk      in   clock
//   i_we     in   write enable
//   i_waddr  in   write address
//   i_wdata  in   write data
//   i_raddr  in   read address
//   o_rdata  out  read data (combinational from i_raddr)
// -----------------------------------------------------------------------------
module rx_frame_parser_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] w_words [DEPTH];

  // Contents are never read before being written within the same frame,
  // so the storage carries no reset.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      logic [DATA_WIDTH-1:0] r_word;

      always_ff @(posedge clk) begin
        if (i_we && (i_waddr == ADDR_W'(gi))) begin
          r_word <= i_wdata;
        end
      end

      assign w_words[gi] = r_word;
    end
  endgenerate

  assign o_rdata = w_words[i_raddr];

endmodule

// File: rtl/rx_frame_parser.sv
// -----------------------------------------------------------------------------
// rx_frame_parser
//   Extracts framed commands from the post-FIFO UART receive byte stream.
//   Frame: SOF, CMD, LEN, LEN payload bytes, CHK (XOR of CMD, LEN, payload).
//   Payload is buffered and only released downstream once the checksum passes;
//   bad, oversize or stalled frames are dropped with a one-cycle error pulse.
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   in_data/in_valid/in_ready    incoming byte stream
//   out_data/out_valid/out_ready payload stream, out_last marks the final byte
//   frame_ok                     pulse: good frame accepted
//   frame_cmd/frame_len          CMD/LEN of the most recent good frame
//   err_chk/err_len/err_timeout  pulses: checksum, oversize LEN, idle timeout
//   busy                         parser is inside a frame or emitting payload
// -----------------------------------------------------------------------------
module rx_frame_parser
  import rx_frame_parser_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    MAX_LEN      = 16,
  parameter logic [DATA_WIDTH-1:0] SOF_BYTE     = DATA_WIDTH'(SOF_DEFAULT),
  parameter int                    BAUDRATE     = 9600,
  parameter int                    CLK_FREQ_MHZ = 125,
  parameter int                    TIMEOUT_CYC  = timeout_default(CLK_FREQ_MHZ, BAUDRATE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         frame_ok,
  output logic [DATA_WIDTH-1:0]        frame_cmd,
  output logic [$clog2(MAX_LEN+1)-1:0] frame_len,
  output logic                         err_chk,
  output logic                         err_len,
  output logic                         err_timeout,
  output logic                         busy
);

  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMR_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [DATA_WIDTH-1:0] MAX_LEN_D = DATA_WIDTH'(MAX_LEN);
  localparam logic [TMR_W-1:0]      TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);

  state_e                r_state;
  state_e                w_state_next;

  logic [DATA_WIDTH-1:0] r_cmd;
  logic [DATA_WIDTH-1:0] r_chk;
  logic [LEN_W-1:0]      r_len;
  logic [LEN_W-1:0]      r_wr_idx;
  logic [LEN_W-1:0]      r_rd_idx;
  logic [TMR_W-1:0]      r_timer;

  logic                  r_frame_ok;
  logic                  r_err_chk;
  logic                  r_err_len;
  logic                  r_err_timeout;
  logic [DATA_WIDTH-1:0] r_frame_cmd;
  logic [LEN_W-1:0]      r_frame_len;

  logic                  w_accept;
  logic                  w_in_frame;
  logic                  w_timeout;
  logic                  w_len_bad;
  logic                  w_pay_last;
  logic                  w_chk_good;
  logic                  w_send_last;
  logic                  w_set_frame_ok;
  logic                  w_set_err_chk;
  logic                  w_set_err_len;
  logic                  w_set_err_to;
  logic                  w_buf_we;
  logic [DATA_WIDTH-1:0] w_buf_rdata;

  // Stall input while payload drains, and during reset.
  assign in_ready    = ~rst & (r_state != ST_SEND);
  assign w_accept    = in_valid & in_ready;

  assign w_in_frame  = (r_state == ST_CMD) || (r_state == ST_LEN) ||
                       (r_state == ST_PAY) || (r_state == ST_CHK);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign w_timeout   = w_in_frame & ~w_accept & (r_timer == TMR_LAST);
  assign w_len_bad   = (in_data > MAX_LEN_D);
  assign w_pay_last  = (r_wr_idx == (r_len - LEN_W'(1)));
  assign w_chk_good  = (in_data == r_chk);
  assign w_send_last = (r_rd_idx == (r_len - LEN_W'(1)));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and event strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_set_frame_ok = 1'b0;
    w_set_err_chk  = 1'b0;
    w_set_err_len  = 1'b0;
    w_set_err_to   = 1'b0;
    w_buf_we       = 1'b0;

    if (w_timeout) begin
      w_state_next = ST_HUNT;
      w_set_err_to = 1'b1;
    end else begin
      case (r_state)
        ST_HUNT: begin
          if (w_accept && (in_data == SOF_BYTE)) begin
            w_state_next = ST_CMD;
          end
        end
        ST_CMD: begin
          if (w_accept) begin
            w_state_next = ST_LEN;
          end
        end
        ST_LEN: begin
          if (w_accept) begin
            if (w_len_bad) begin
              w_set_err_len = 1'b1;
              w_state_next  = ST_HUNT;
            end else if (in_data == '0) begin
              w_state_next = ST_CHK;
            end else begin
              w_state_next = ST_PAY;
            end
          end
        end
        ST_PAY: begin
          // SOF_BYTE is ordinary payload here.
          if (w_accept) begin
            w_buf_we = 1'b1;
            if (w_pay_last) begin
              w_state_next = ST_CHK;
            end
          end
        end
        ST_CHK: begin
          if (w_accept) begin
            if (w_chk_good) begin
              w_set_frame_ok = 1'b1;
              w_state_next   = (r_len == '0) ? ST_HUNT : ST_SEND;
            end else begin
              w_set_err_chk = 1'b1;
              w_state_next  = ST_HUNT;
            end
          end
        end
        ST_SEND: begin
          if (out_ready && w_send_last) begin
            w_state_next = ST_HUNT;
          end
        end
        default: begin
          w_state_next = ST_HUNT;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: header capture, checksum, indices, timer, status pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd         <= '0;
      r_chk         <= '0;
      r_len         <= '0;
      r_wr_idx      <= '0;
      r_rd_idx      <= '0;
      r_timer       <= '0;
      r_frame_ok    <= 1'b0;
      r_err_chk     <= 1'b0;
      r_err_len     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_frame_cmd   <= '0;
      r_frame_len   <= '0;
    end else begin
      r_frame_ok    <= w_set_frame_ok;
      r_err_chk     <= w_set_err_chk;
      r_err_len     <= w_set_err_len;
      r_err_timeout <= w_set_err_to;

      if (w_set_frame_ok) begin
        r_frame_cmd <= r_cmd;
        r_frame_len <= r_len;
      end

      if (w_accept) begin
        case (r_state)
          ST_CMD: begin
            r_cmd <= in_data;
            r_chk <= in_data;
          end
          ST_LEN: begin
            if (!w_len_bad) begin
              r_len    <= in_data[LEN_W-1:0];
              r_chk    <= r_chk ^ in_data;
              r_wr_idx <= '0;
            end
          end
          ST_PAY: begin
            r_chk    <= r_chk ^ in_data;
            r_wr_idx <= r_wr_idx + LEN_W'(1);
          end
          default: begin
          end
        endcase
      end

      if ((r_state == ST_CHK) && w_accept) begin
        r_rd_idx <= '0;
      end else if ((r_state == ST_SEND) && out_ready) begin
        r_rd_idx <= r_rd_idx + LEN_W'(1);
      end

      // Timer runs only while waiting for the next byte of a frame.
      if (w_in_frame && !w_accept && !w_timeout) begin
        r_timer <= r_timer + TMR_W'(1);
      end else begin
        r_timer <= '0;
      end
    end
  end

  rx_frame_parser_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_LEN),
    .ADDR_W     (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_buf_we),
    .i_waddr (r_wr_idx[ADDR_W-1:0]),
    .i_wdata (in_data),
    .i_raddr (r_rd_idx[ADDR_W-1:0]),
    .o_rdata (w_buf_rdata)
  );

  // Payload outputs derive from state and read index only, so they hold
  // steady while the consumer stalls.
  assign out_valid   = (r_state == ST_SEND);
  assign out_data    = w_buf_rdata;
  assign out_last    = out_valid & w_send_last;

  assign frame_ok    = r_frame_ok;
  assign frame_cmd   = r_frame_cmd;
  assign frame_len   = r_frame_len;
  assign err_chk     = r_err_chk;
  assign err_len     = r_err_len;
  assign err_timeout = r_err_timeout;
  assign busy        = (r_state != ST_HUNT);

endmodule
